sobel_data_modulator: RTL and testbench

//  Front-end window builder for the Sobel edge pipeline. Takes one vertical 3-pixel column per

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_row_shift.sv | 44 ++++
 rtl/sobel_data_modulator.sv | 88 ++++++++
 tb/tb_sobel_data_modulator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths and window types for the Sobel window builder
package sobel_pkg;

    localparam int DATA_W  = 8;
    localparam int WIN_DIM = 3;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef pixel_t [WIN_DIM-1:0] win_row_t;

    // Saturating increment used by the window fill counter
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

endpackage

// File: rtl/sobel_row_shift.sv
// rtl/sobel_row_shift.sv - one 3-tap pixel shift register for a single window row
module sobel_row_shift
    import sobel_pkg::*;
#(
    parameter int DATA_W = sobel_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] pix_i,
    output logic [DATA_W-1:0] tap0_o,
    output logic [DATA_W-1:0] tap1_o,
    output logic [DATA_W-1:0] tap2_o
);

    // Tap 0 is the oldest column, tap WIN_DIM-1 the newest
    logic [WIN_DIM-1:0][DATA_W-1:0] taps_q;
    logic [WIN_DIM-1:0][DATA_W-1:0] taps_d;

    // Shift toward the oldest tap and append the new pixel when enabled
    always_comb begin
        taps_d = taps_q;
        if (en_i) begin
            for (int i = 0; i < WIN_DIM - 1; i++) begin
                taps_d[i] = taps_q[i+1];
            end
            taps_d[WIN_DIM-1] = pix_i;
        end
    end

    // Tap storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign tap0_o = taps_q[0];
    assign tap1_o = taps_q[1];
    assign tap2_o = taps_q[2];

endmodule

// File: rtl/sobel_data_modulator.sv
// rtl/sobel_data_modulator.sv - 3x3 sliding window builder (option: SOBEL_MOD_RESTART_EN)
module sobel_data_modulator
    import sobel_pkg::*;
#(
    parameter int DATA_W = sobel_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d0_i,
    input  logic [DATA_W-1:0] d1_i,
    input  logic [DATA_W-1:0] d2_i,
    input  logic              done_i,
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic [DATA_W-1:0] d4_o,
    output logic [DATA_W-1:0] d5_o,
    output logic [DATA_W-1:0] d6_o,
    output logic [DATA_W-1:0] d7_o,
    output logic [DATA_W-1:0] d8_o,
    output logic              done_o
);

    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       done_q;
    logic       done_d;

    sobel_row_shift #(.DATA_W(DATA_W)) u_row_top (
        .clk    (clk),
        .rst    (rst),
        .en_i   (done_i),
        .pix_i  (d0_i),
        .tap0_o (d0_o),
        .tap1_o (d1_o),
        .tap2_o (d2_o)
    );

    sobel_row_shift #(.DATA_W(DATA_W)) u_row_mid (
        .clk    (clk),
        .rst    (rst),
        .en_i   (done_i),
        .pix_i  (d1_i),
        .tap0_o (d3_o),
        .tap1_o (d4_o),
        .tap2_o (d5_o)
    );

    sobel_row_shift #(.DATA_W(DATA_W)) u_row_bot (
        .clk    (clk),
        .rst    (rst),
        .en_i   (done_i),
        .pix_i  (d2_i),
        .tap0_o (d6_o),
        .tap1_o (d7_o),
        .tap2_o (d8_o)
    );

    // Fill count saturates at a full window; done follows every accepted column once full
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (done_i) begin
            count_d = sat_inc2(count_q);
            done_d  = (count_d == 2'd3);
        end else begin
`ifdef SOBEL_MOD_RESTART_EN
            // A gap marks a new line: old columns no longer form a valid window
            count_d = 2'd0;
`endif
        end
    end

    // Fill count and registered window-valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: tb/tb_sobel_data_modulator.sv
// tb/tb_sobel_data_modulator.sv - scoreboard bench for the Sobel window builder
module tb_sobel_data_modulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0_i, d1_i, d2_i;
    logic       done_i;
    logic [7:0] d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;
    logic       done_o;

    typedef struct packed {
        logic [8:0][7:0] w;
        logic            done;
    } exp_t;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [8:0][7:0] m_win    = '0;
    logic [1:0]      m_cnt    = 2'd0;
    logic            m_done   = 1'b0;

    always #5 clk = ~clk;

    sobel_data_modulator dut (
        .clk    (clk),
        .rst    (rst),
        .d0_i   (d0_i),
        .d1_i   (d1_i),
        .d2_i   (d2_i),
        .done_i (done_i),
        .d0_o   (d0_o),
        .d1_o   (d1_o),
        .d2_o   (d2_o),
        .d3_o   (d3_o),
        .d4_o   (d4_o),
        .d5_o   (d5_o),
        .d6_o   (d6_o),
        .d7_o   (d7_o),
        .d8_o   (d8_o),
        .done_o (done_o)
    );

    function automatic logic [8:0][7:0] dut_win();
        logic [8:0][7:0] w;
        w[0] = d0_o; w[1] = d1_o; w[2] = d2_o;
        w[3] = d3_o; w[4] = d4_o; w[5] = d5_o;
        w[6] = d6_o; w[7] = d7_o; w[8] = d8_o;
        return w;
    endfunction

    function automatic logic [8:0][7:0] mk_win(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        logic [8:0][7:0] w;
        w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2);
        w[3] = 8'(a3); w[4] = 8'(a4); w[5] = 8'(a5);
        w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
        return w;
    endfunction

    task automatic check_now(input string name, input logic [8:0][7:0] w, input logic d);
        n_checks++;
        if (dut_win() !== w || done_o !== d) begin
            n_fail++;
            $display("FAIL %s: got win=%h done=%b, want win=%h done=%b",
                     name, dut_win(), done_o, w, d);
        end
    endtask

    // Drive one cycle of input and push the window expected after the next edge
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_t e;
        @(negedge clk);
        d0_i = a; d1_i = b; d2_i = c; done_i = v;
        if (!rst) begin
            m_win = '0; m_cnt = 2'd0; m_done = 1'b0;
        end else if (v) begin
            m_win[0] = m_win[1]; m_win[1] = m_win[2]; m_win[2] = a;
            m_win[3] = m_win[4]; m_win[4] = m_win[5]; m_win[5] = b;
            m_win[6] = m_win[7]; m_win[7] = m_win[8]; m_win[8] = c;
            if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            m_done = (m_cnt == 2'd3);
        end else begin
`ifdef SOBEL_MOD_RESTART_EN
            m_cnt = 2'd0;
`endif
            m_done = 1'b0;
        end
        e.w    = m_win;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expected cycle just after the active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_win() !== e.w || done_o !== e.done) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got win=%h done=%b, want win=%h done=%b",
                             $time, dut_win(), done_o, e.w, e.done);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; done_i = 1'b1;
        d0_i = 8'h77; d1_i = 8'h88; d2_i = 8'h99;

        // Reset holds everything at zero despite active input
        step(1'b1, 8'h77, 8'h88, 8'h99);
        step(1'b0, 8'h77, 8'h88, 8'h99);
        after_edge();
        check_now("reset", '0, 1'b0);

        @(negedge clk);
        rst = 1'b1;

        // Fill
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 8'(i), 8'(i + 1), 8'(i + 2));
        end
        after_edge();
        check_now("fill", mk_win(1, 2, 3, 2, 3, 4, 3, 4, 5), 1'b1);

        // Stream
        for (int i = 4; i <= 30; i++) begin
            step(1'b1, 8'(i), 8'(i + 1), 8'(i + 2));
        end
        after_edge();
        check_now("stream_end", mk_win(28, 29, 30, 29, 30, 31, 30, 31, 32), 1'b1);

        // Gap of two cycles then resume
        step(1'b0, 8'hEE, 8'hEE, 8'hEE);
        step(1'b0, 8'hDD, 8'hDD, 8'hDD);
        after_edge();
        check_now("gap_frozen", mk_win(28, 29, 30, 29, 30, 31, 30, 31, 32), 1'b0);
        step(1'b1, 8'd31, 8'd32, 8'd33);
        after_edge();
`ifdef SOBEL_MOD_RESTART_EN
        check_now("gap_resume1", mk_win(29, 30, 31, 30, 31, 32, 31, 32, 33), 1'b0);
`else
        check_now("gap_resume1", mk_win(29, 30, 31, 30, 31, 32, 31, 32, 33), 1'b1);
`endif
        step(1'b1, 8'd32, 8'd33, 8'd34);
        step(1'b1, 8'd33, 8'd34, 8'd35);
        step(1'b1, 8'd34, 8'd35, 8'd36);

        // Asynchronous reset pulse between edges
        after_edge();
        #2;
        rst = 1'b0;
        #1;
        check_now("async_reset", '0, 1'b0);
        m_win = '0; m_cnt = 2'd0; m_done = 1'b0;
        @(negedge clk);
        done_i = 1'b0;
        rst = 1'b1;
        for (int i = 40; i <= 42; i++) begin
            step(1'b1, 8'(i), 8'(i + 1), 8'(i + 2));
        end
        after_edge();
        check_now("refill", mk_win(40, 41, 42, 41, 42, 43, 42, 43, 44), 1'b1);

        // Bit-exact pass-through of extreme patterns
        step(1'b1, 8'hFF, 8'h00, 8'hA5);
        step(1'b1, 8'h00, 8'hA5, 8'hFF);
        step(1'b1, 8'hA5, 8'hFF, 8'h00);
        after_edge();
        check_now("width", mk_win(8'hFF, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'hFF, 8'hA5, 8'hFF, 8'h00), 1'b1);

        @(negedge clk);
        done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
